traffic_phase_timer: RTL and testbench

Timing master for the traffic light controller. It watches the controller's lamp outputs, works out the current phase, and holds each phase for a programmable number of clock cycles. It then issues the one-cycle `en` step pulse that advances the controller. It also counts completed signal cycles and latches a fault on illegal lamp patterns or a controller that stops responding.

---
 rtl/traffic_phase_timer.sv | 197 +++++++++++++++++++
 tb/tb_traffic_phase_timer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: decodes the controller's lamps, times each phase and issues the one-cycle en step.
// Optional fault detection (illegal lamps, unresponsive controller) is enabled by defining TRAFFIC_FAULT_DETECT_EN.
module traffic_phase_timer #(
  parameter int GREEN_TICKS  = 40,
  parameter int YELLOW_TICKS = 8,
  parameter int ALLRED_TICKS = 4,
  parameter int PED_TICKS    = 20,
  parameter int WAIT_MAX     = 8,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       MG,
  input  logic       MY,
  input  logic       MR,
  input  logic       SG,
  input  logic       SY,
  input  logic       SR,
  input  logic       pedLight,
  input  logic       newCycle,
  output logic       en,
  output logic [2:0] phase,
  output logic [7:0] cycleCount,
  output logic       fault
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_COUNT,
    ST_FIRE,
    ST_WAIT
`ifdef TRAFFIC_FAULT_DETECT_EN
    , ST_FAULT
`endif
  } state_e;

  typedef enum logic [2:0] {
    PH_GR      = 3'd0,
    PH_YR      = 3'd1,
    PH_RR      = 3'd2,
    PH_RG      = 3'd3,
    PH_RY      = 3'd4,
    PH_PED     = 3'd5,
    PH_ILLEGAL = 3'd7
  } phase_e;

  logic [7:0]        lampRaw, lampS1_q, lampS2_q;
  logic              ncPrev_q;
  logic [1:0]        settle_q, settle_d;
  state_e            state_q, state_d;
  phase_e            phase_q, phase_d, decPhase;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cntDec, dwellM1;
  logic [WAIT_W-1:0] wait_q, wait_d, waitInc;
  logic              en_q, en_d;
  logic [7:0]        cycleCount_q, cycleCount_d;
  logic              settled;

  // Lamps are asynchronous to clk; only the second flop is ever observed.
  assign lampRaw = {MG, MY, MR, SG, SY, SR, pedLight, newCycle};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lampS1_q <= '0;
      lampS2_q <= '0;
      ncPrev_q <= 1'b0;
    end else begin
      lampS1_q <= lampRaw;
      lampS2_q <= lampS1_q;
      ncPrev_q <= lampS2_q[0];
    end
  end

  // Strict decode: exactly one lamp per street, walk lamp only with both streets red.
  always_comb begin
    case (lampS2_q[7:1])
      7'b100_001_0: decPhase = PH_GR;
      7'b010_001_0: decPhase = PH_YR;
      7'b001_001_0: decPhase = PH_RR;
      7'b001_100_0: decPhase = PH_RG;
      7'b001_010_0: decPhase = PH_RY;
      7'b001_001_1: decPhase = PH_PED;
      default:      decPhase = PH_ILLEGAL;
    endcase
  end

  always_comb begin
    case (decPhase)
      PH_GR, PH_RG: dwellM1 = CNT_W'(GREEN_TICKS - 1);
      PH_YR, PH_RY: dwellM1 = CNT_W'(YELLOW_TICKS - 1);
      PH_RR:        dwellM1 = CNT_W'(ALLRED_TICKS - 1);
      PH_PED:       dwellM1 = CNT_W'(PED_TICKS - 1);
      default:      dwellM1 = '0;
    endcase
  end

  assign settled  = (settle_q == 2'd2);
  assign settle_d = settled ? settle_q : settle_q + 2'd1;
  assign cntDec   = cnt_q - CNT_W'(1);
  assign waitInc  = wait_q + WAIT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    phase_d = phase_q;
    case (state_q)
      ST_LOAD: begin
        if (decPhase != PH_ILLEGAL) begin
          phase_d = decPhase;
          cnt_d   = dwellM1;
          state_d = (dwellM1 == '0) ? ST_FIRE : ST_COUNT;
        end
      end
      ST_COUNT: begin
        cnt_d = cntDec;
        if (cntDec == '0) state_d = ST_FIRE;
      end
      ST_FIRE: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (decPhase != phase_q) begin
          state_d = ST_LOAD;
        end else begin
          wait_d = waitInc;
          if (waitInc == WAIT_W'(WAIT_MAX)) begin
`ifdef TRAFFIC_FAULT_DETECT_EN
            state_d = ST_FAULT;
`else
            state_d = ST_LOAD;
`endif
          end
        end
      end
`ifdef TRAFFIC_FAULT_DETECT_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_LOAD;
    endcase

    // An illegal lamp pattern overrides every other transition once the synchronizer has filled.
    if ((decPhase == PH_ILLEGAL) && settled) begin
`ifdef TRAFFIC_FAULT_DETECT_EN
      if (state_q != ST_FAULT) begin
        state_d = ST_FAULT;
        phase_d = PH_ILLEGAL;
      end
`else
      state_d = ST_LOAD;
`endif
    end
  end

  assign en_d         = (state_d == ST_FIRE);
  assign cycleCount_d = (lampS2_q[0] && !ncPrev_q) ? cycleCount_q + 8'd1 : cycleCount_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      settle_q     <= 2'd0;
      cnt_q        <= '0;
      wait_q       <= '0;
      phase_q      <= PH_GR;
      en_q         <= 1'b0;
      cycleCount_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      phase_q      <= phase_d;
      en_q         <= en_d;
      cycleCount_q <= cycleCount_d;
    end
  end

`ifdef TRAFFIC_FAULT_DETECT_EN
  logic fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= (state_d == ST_FAULT);
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign en         = en_q;
  assign phase      = phase_q;
  assign cycleCount = cycleCount_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed self-checking bench for traffic_phase_timer; expectations follow TRAFFIC_FAULT_DETECT_EN when defined.
module tb_traffic_phase_timer;

  localparam int G = 4;
  localparam int Y = 3;
  localparam int A = 1;
  localparam int P = 5;
  localparam int W = 8;

  // Lamp vectors: {MG, MY, MR, SG, SY, SR, pedLight, newCycle}
  localparam logic [7:0] L_GR   = 8'b100_001_0_1;
  localparam logic [7:0] L_GR0  = 8'b100_001_0_0;
  localparam logic [7:0] L_YR   = 8'b010_001_0_0;
  localparam logic [7:0] L_RR   = 8'b001_001_0_0;
  localparam logic [7:0] L_RG   = 8'b001_100_0_0;
  localparam logic [7:0] L_RY   = 8'b001_010_0_0;
  localparam logic [7:0] L_PED  = 8'b001_001_1_0;
  localparam logic [7:0] L_BAD  = 8'b100_100_0_0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       MG = 0, MY = 0, MR = 0, SG = 0, SY = 0, SR = 0, pedLight = 0, newCycle = 0;
  logic       en;
  logic [2:0] phase;
  logic [7:0] cycleCount;
  logic       fault;

  int checkCount = 0;
  int errorCount = 0;

  traffic_phase_timer #(
    .GREEN_TICKS (G),
    .YELLOW_TICKS(Y),
    .ALLRED_TICKS(A),
    .PED_TICKS   (P),
    .WAIT_MAX    (W),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MG        (MG),
    .MY        (MY),
    .MR        (MR),
    .SG        (SG),
    .SY        (SY),
    .SR        (SR),
    .pedLight  (pedLight),
    .newCycle  (newCycle),
    .en        (en),
    .phase     (phase),
    .cycleCount(cycleCount),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] lamps);
    {MG, MY, MR, SG, SY, SR, pedLight, newCycle} = lamps;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges with the given lamps, then releases it just after an edge.
  task automatic doReset(input logic [7:0] lamps);
    reset = 1'b1;
    applyStimulus(lamps);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic waitEn(input string tag, input int maxCycles, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!en && cycles < maxCycles);
    checkOutput(tag, {31'd0, en}, 32'd1);
  endtask

  function automatic int durOf(input logic [2:0] ph);
    case (ph)
      3'd0, 3'd3: return G;
      3'd1, 3'd4: return Y;
      3'd2:       return A;
      default:    return P;
    endcase
  endfunction

  logic [7:0] seqLamps [8];
  logic [2:0] seqPhase [8];
  int         cyc;
  int         enPulses;

  initial begin
    seqLamps = '{L_GR, L_YR, L_RR, L_RG, L_RY, L_RR, L_PED, L_GR};
    seqPhase = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd5, 3'd0};

    // Reset state
    doReset(L_GR);
    reset = 1'b1;
    tick();
    checkOutput("resetEn", {31'd0, en}, 32'd0);
    checkOutput("resetFault", {31'd0, fault}, 32'd0);
    checkOutput("resetPhase", {29'd0, phase}, 32'd0);
    checkOutput("resetCycleCount", {24'd0, cycleCount}, 32'd0);

    // Behavioural controller stepping through a full signal cycle on each en
    doReset(L_GR);
    for (int i = 0; i < 8; i++) begin
      waitEn($sformatf("seqEn%0d", i), 40, cyc);
      checkOutput($sformatf("seqSpacing%0d", i), cyc, (i == 0) ? 2 + G : durOf(seqPhase[i]) + 3);
      checkOutput($sformatf("seqPhase%0d", i), {29'd0, phase}, {29'd0, seqPhase[i]});
      if (i == 0) checkOutput("seqCycleCountFirst", {24'd0, cycleCount}, 32'd1);
      if (i == 7) checkOutput("seqCycleCountLast", {24'd0, cycleCount}, 32'd2);
      if (i < 7) applyStimulus(seqLamps[i + 1]);
    end

    // Lamps held static after the last en
`ifdef TRAFFIC_FAULT_DETECT_EN
    enPulses = 0;
    for (int i = 0; i < W; i++) begin
      tick();
      if (en) enPulses++;
    end
    checkOutput("timeoutFaultBefore", {31'd0, fault}, 32'd0);
    tick();
    checkOutput("timeoutFaultAfter", {31'd0, fault}, 32'd1);
    checkOutput("timeoutNoEn", enPulses, 0);
`else
    waitEn("refireEn", 40, cyc);
    checkOutput("refireSpacing", cyc, G + W + 1);
    checkOutput("refireFault", {31'd0, fault}, 32'd0);
    waitEn("refireEn2", 40, cyc);
    checkOutput("refireSpacing2", cyc, G + W + 1);
`endif

    // Reset in the middle of a count
    doReset(L_RG | 8'h01);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("midCountPhase", {29'd0, phase}, 32'd3);
    checkOutput("midCountCycleCount", {24'd0, cycleCount}, 32'd1);
    applyStimulus(L_GR);
    reset = 1'b1;
    #1;
    checkOutput("midResetEn", {31'd0, en}, 32'd0);
    checkOutput("midResetFault", {31'd0, fault}, 32'd0);
    checkOutput("midResetPhase", {29'd0, phase}, 32'd0);
    checkOutput("midResetCycleCount", {24'd0, cycleCount}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    waitEn("restartEn", 40, cyc);
    checkOutput("restartSpacing", cyc, 2 + G);
    checkOutput("restartPhase", {29'd0, phase}, 32'd0);
    tick();
    checkOutput("restartEnWidth", {31'd0, en}, 32'd0);

    // Illegal pattern during COUNT, arriving on the cycle en would have fired
    doReset(L_GR0);
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(L_BAD);
    tick();
    tick();
    checkOutput("illegalPhaseBefore", {29'd0, phase}, 32'd0);
    checkOutput("illegalFaultBefore", {31'd0, fault}, 32'd0);
    tick();
    checkOutput("illegalEnSuppressed", {31'd0, en}, 32'd0);
`ifdef TRAFFIC_FAULT_DETECT_EN
    checkOutput("illegalPhase", {29'd0, phase}, 32'd7);
    checkOutput("illegalFault", {31'd0, fault}, 32'd1);
`else
    checkOutput("illegalPhaseHeld", {29'd0, phase}, 32'd0);
    checkOutput("illegalFaultTied", {31'd0, fault}, 32'd0);
`endif
    enPulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (en) enPulses++;
    end
    checkOutput("illegalNoEn", enPulses, 0);
`ifdef TRAFFIC_FAULT_DETECT_EN
    applyStimulus(L_GR0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (en) enPulses++;
    end
    checkOutput("faultStickyEn", enPulses, 0);
    checkOutput("faultSticky", {31'd0, fault}, 32'd1);
`else
    applyStimulus(L_GR0);
    waitEn("recoverEn", 40, cyc);
    checkOutput("recoverSpacing", cyc, 2 + G);
`endif

    // cycleCount wrap over 256 newCycle pulses
    doReset(L_GR0);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(L_GR);
      tick();
      tick();
      applyStimulus(L_GR0);
      tick();
      tick();
      if (i == 254) checkOutput("cycleCount255", {24'd0, cycleCount}, 32'd255);
    end
    checkOutput("cycleCountWrap", {24'd0, cycleCount}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
